// File: rtl/uart_pkg.sv
// Shared UART receive-side definitions: frame geometry and receiver state encodings.
// RX_ names keep the receiver states apart from the transmitter's own enum.
package uart_pkg;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        RX_IDLE  = 3'b000,
        RX_START = 3'b001,
        RX_DATA  = 3'b010,
        RX_STOP  = 3'b011,
        RX_BREAK = 3'b100
    } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous serial line; resets to the idle (high) level
// so a freshly released receiver never sees a false start bit.
module uart_rx_sync (
    input  logic clk_in,
    input  logic reset,
    input  logic async_bit,
    output logic sync_bit
);

    logic meta;

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            meta     <= 1'b1;
            sync_bit <= 1'b1;
        end else begin
            meta     <= async_bit;
            sync_bit <= meta;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: oversampled by sample_tick, samples each bit at its centre and
// strobes data_valid on a good stop bit or frame_err on a low stop bit.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int DATA_BITS  = UART_DATA_BITS
) (
    input  logic                 clk_in,
    input  logic                 reset,
    input  logic                 sample_tick,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    rx_state_t             state, state_next;
    logic [TICK_W-1:0]     tick_cnt, tick_next;
    logic [BIT_W-1:0]      bit_cnt, bit_next;
    logic [DATA_BITS-1:0]  shift_reg, shift_next;
    logic [DATA_BITS-1:0]  data_next;
    logic                  valid_next, err_next;
    logic                  rx_s;

    uart_rx_sync u_sync (
        .clk_in    (clk_in),
        .reset     (reset),
        .async_bit (rx_in),
        .sync_bit  (rx_s)
    );

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state      <= RX_IDLE;
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_next;
            tick_cnt   <= tick_next;
            bit_cnt    <= bit_next;
            shift_reg  <= shift_next;
            data_out   <= data_next;
            data_valid <= valid_next;
            frame_err  <= err_next;
        end
    end

    // Everything holds between ticks; the strobes default low so they last one cycle.
    always_comb begin
        state_next = state;
        tick_next  = tick_cnt;
        bit_next   = bit_cnt;
        shift_next = shift_reg;
        data_next  = data_out;
        valid_next = 1'b0;
        err_next   = 1'b0;

        if (sample_tick) begin
            case (state)
                RX_IDLE: begin
                    if (!rx_s) begin
                        state_next = RX_START;
                        tick_next  = '0;
                    end
                end
                RX_START: begin
                    if (tick_cnt == TICK_MID) begin
                        tick_next  = '0;
                        bit_next   = '0;
                        state_next = rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        tick_next = tick_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (tick_cnt == TICK_LAST) begin
                        shift_next = {rx_s, shift_reg[DATA_BITS-1:1]};
                        tick_next  = '0;
                        bit_next   = bit_cnt + 1'b1;
                        if (bit_cnt == BIT_LAST) begin
                            bit_next   = '0;
                            state_next = RX_STOP;
                        end
                    end else begin
                        tick_next = tick_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    // Leaving at mid-stop lets a back-to-back start bit be caught.
                    if (tick_cnt == TICK_LAST) begin
                        tick_next = '0;
                        if (rx_s) begin
                            data_next  = shift_reg;
                            valid_next = 1'b1;
                            state_next = RX_IDLE;
                        end else begin
                            err_next   = 1'b1;
                            state_next = RX_BREAK;
                        end
                    end else begin
                        tick_next = tick_cnt + 1'b1;
                    end
                end
                RX_BREAK: begin
                    if (rx_s) begin
                        state_next = RX_IDLE;
                    end
                end
                default: begin
                    state_next = RX_IDLE;
                    tick_next  = '0;
                    bit_next   = '0;
                end
            endcase
        end
    end

    assign busy = (state != RX_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed self-checking bench for uart_receiver: good frames, glitch, framing error
// with break, back-to-back frames, mid-frame reset and a sparse sample_tick.
module tb_uart_receiver;

    logic       clk_in;
    logic       reset;
    logic       sample_tick;
    logic       rx_in;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       busy;

    int total;
    int bad;
    int tick_period;
    int cycle;

    int         valid_hi;
    int         err_hi;
    int         both_hi;
    logic       valid_prev;
    logic       tick_at_edge;
    logic [7:0] valid_vals[$];
    int         valid_cycles[$];
    logic       valid_ticks[$];

    uart_receiver #(
        .OVERSAMPLE (16),
        .DATA_BITS  (8)
    ) dut (
        .clk_in      (clk_in),
        .reset       (reset),
        .sample_tick (sample_tick),
        .rx_in       (rx_in),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .frame_err   (frame_err),
        .busy        (busy)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) begin
        cycle        <= cycle + 1;
        tick_at_edge <= sample_tick;
    end

    // Pulse recorder, sampled mid-cycle away from the active edge.
    always @(negedge clk_in) begin
        if (data_valid) begin
            valid_hi = valid_hi + 1;
            if (!valid_prev) begin
                valid_vals.push_back(data_out);
                valid_cycles.push_back(cycle);
                valid_ticks.push_back(tick_at_edge);
            end
        end
        if (frame_err) err_hi = err_hi + 1;
        if (data_valid && frame_err) both_hi = both_hi + 1;
        valid_prev = data_valid;
    end

    task do_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            sample_tick = 1'b1;
            @(posedge clk_in);
            #1;
            sample_tick = 1'b0;
            for (int j = 1; j < tick_period; j++) begin
                @(posedge clk_in);
                #1;
            end
        end
    endtask

    task send_frame(input logic [7:0] value, input logic stop);
        rx_in = 1'b0;
        do_ticks(16);
        for (int i = 0; i < 8; i++) begin
            rx_in = value[i];
            do_ticks(16);
        end
        rx_in = stop;
        do_ticks(16);
        rx_in = 1'b1;
    endtask

    task test_reset;
        reset = 1'b0;
        rx_in = 1'b1;
        sample_tick = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        total++; if (data_out !== 8'h00) begin bad++; $display("[TB] FAIL reset_data: got %h expected 00", data_out); end
        total++; if (data_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %b expected 0", data_valid); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("[TB] FAIL reset_err: got %b expected 0", frame_err); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        reset = 1'b1;
        do_ticks(4);
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL idle_busy: got %b expected 0", busy); end
    endtask

    task test_frame_a5;
        int v0, e0, n0;
        v0 = valid_hi; e0 = err_hi; n0 = valid_vals.size();
        send_frame(8'hA5, 1'b1);
        do_ticks(4);
        total++; if (data_out !== 8'hA5) begin bad++; $display("[TB] FAIL a5_data: got %h expected a5", data_out); end
        total++; if (valid_hi - v0 !== 1) begin bad++; $display("[TB] FAIL a5_valid_cycles: got %0d expected 1", valid_hi - v0); end
        total++; if (err_hi - e0 !== 0) begin bad++; $display("[TB] FAIL a5_err: got %0d expected 0", err_hi - e0); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL a5_busy: got %b expected 0", busy); end
        total++;
        if (valid_vals.size() != n0 + 1) begin
            bad++; $display("[TB] FAIL a5_strobe_count: got %0d expected 1", valid_vals.size() - n0);
        end else if (valid_vals[n0] !== 8'hA5) begin
            bad++; $display("[TB] FAIL a5_strobe_value: got %h expected a5", valid_vals[n0]);
        end
    endtask

    task test_glitch;
        int v0, e0;
        v0 = valid_hi; e0 = err_hi;
        rx_in = 1'b0;
        do_ticks(4);
        total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL glitch_busy_start: got %b expected 1", busy); end
        rx_in = 1'b1;
        do_ticks(10);
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL glitch_busy_end: got %b expected 0", busy); end
        total++; if (valid_hi - v0 !== 0) begin bad++; $display("[TB] FAIL glitch_valid: got %0d expected 0", valid_hi - v0); end
        total++; if (err_hi - e0 !== 0) begin bad++; $display("[TB] FAIL glitch_err: got %0d expected 0", err_hi - e0); end
    endtask

    task test_break;
        int v0, e0;
        v0 = valid_hi; e0 = err_hi;
        send_frame(8'h3C, 1'b0);
        rx_in = 1'b0;
        do_ticks(40);
        total++; if (err_hi - e0 !== 1) begin bad++; $display("[TB] FAIL break_err_cycles: got %0d expected 1", err_hi - e0); end
        total++; if (valid_hi - v0 !== 0) begin bad++; $display("[TB] FAIL break_valid: got %0d expected 0", valid_hi - v0); end
        total++; if (data_out !== 8'hA5) begin bad++; $display("[TB] FAIL break_data_hold: got %h expected a5", data_out); end
        total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL break_busy_low: got %b expected 1", busy); end
        rx_in = 1'b1;
        do_ticks(4);
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL break_release_busy: got %b expected 0", busy); end
        send_frame(8'h55, 1'b1);
        do_ticks(4);
        total++; if (data_out !== 8'h55) begin bad++; $display("[TB] FAIL after_break_data: got %h expected 55", data_out); end
        total++; if (valid_hi - v0 !== 1) begin bad++; $display("[TB] FAIL after_break_valid: got %0d expected 1", valid_hi - v0); end
        total++; if (err_hi - e0 !== 1) begin bad++; $display("[TB] FAIL after_break_err: got %0d expected 1", err_hi - e0); end
    endtask

    task test_back_to_back;
        int n0;
        n0 = valid_vals.size();
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        do_ticks(4);
        total++;
        if (valid_vals.size() != n0 + 2) begin
            bad++; $display("[TB] FAIL b2b_count: got %0d expected 2", valid_vals.size() - n0);
        end else begin
            total++; if (valid_vals[n0] !== 8'h00) begin bad++; $display("[TB] FAIL b2b_first: got %h expected 00", valid_vals[n0]); end
            total++; if (valid_vals[n0+1] !== 8'hFF) begin bad++; $display("[TB] FAIL b2b_second: got %h expected ff", valid_vals[n0+1]); end
            total++;
            if (valid_cycles[n0+1] - valid_cycles[n0] != 160) begin
                bad++; $display("[TB] FAIL b2b_spacing: got %0d expected 160", valid_cycles[n0+1] - valid_cycles[n0]);
            end
        end
        total++; if (data_out !== 8'hFF) begin bad++; $display("[TB] FAIL b2b_data: got %h expected ff", data_out); end
    endtask

    task test_reset_mid_frame;
        int v0;
        logic [7:0] partial;
        partial = 8'h81;
        rx_in = 1'b0;
        do_ticks(16);
        for (int i = 0; i < 3; i++) begin
            rx_in = partial[i];
            do_ticks(16);
        end
        total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL midrst_busy_before: got %b expected 1", busy); end
        reset = 1'b0;
        #1;
        total++; if (data_out !== 8'h00) begin bad++; $display("[TB] FAIL midrst_data: got %h expected 00", data_out); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL midrst_busy: got %b expected 0", busy); end
        total++; if (data_valid !== 1'b0 || frame_err !== 1'b0) begin bad++; $display("[TB] FAIL midrst_strobes: got %b%b expected 00", data_valid, frame_err); end
        rx_in = 1'b1;
        repeat (2) @(posedge clk_in);
        #1;
        reset = 1'b1;
        v0 = valid_hi;
        send_frame(8'h81, 1'b1);
        do_ticks(4);
        total++; if (data_out !== 8'h81) begin bad++; $display("[TB] FAIL midrst_fresh_data: got %h expected 81", data_out); end
        total++; if (valid_hi - v0 !== 1) begin bad++; $display("[TB] FAIL midrst_fresh_valid: got %0d expected 1", valid_hi - v0); end
    endtask

    task test_slow_tick;
        int v0, n0;
        v0 = valid_hi; n0 = valid_vals.size();
        tick_period = 4;
        send_frame(8'h5A, 1'b1);
        do_ticks(4);
        tick_period = 1;
        total++; if (data_out !== 8'h5A) begin bad++; $display("[TB] FAIL slow_data: got %h expected 5a", data_out); end
        total++; if (valid_hi - v0 !== 1) begin bad++; $display("[TB] FAIL slow_valid_cycles: got %0d expected 1", valid_hi - v0); end
        total++;
        if (valid_ticks.size() != n0 + 1) begin
            bad++; $display("[TB] FAIL slow_strobe_count: got %0d expected 1", valid_ticks.size() - n0);
        end else if (valid_ticks[n0] !== 1'b1) begin
            bad++; $display("[TB] FAIL slow_valid_after_tick: got %b expected 1", valid_ticks[n0]);
        end
    endtask

    initial begin
        total = 0; bad = 0; tick_period = 1; cycle = 0;
        valid_hi = 0; err_hi = 0; both_hi = 0; valid_prev = 1'b0;
        test_reset;
        test_frame_a5;
        test_glitch;
        test_break;
        test_back_to_back;
        test_reset_mid_frame;
        test_slow_tick;
        total++; if (both_hi !== 0) begin bad++; $display("[TB] FAIL strobe_overlap: got %0d expected 0", both_hi); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Serial-to-parallel receive stage on the downstream side of the transmit line. It consumes the 8N1 frame driven by the counter's UART transmitter and recovers the byte.
- The line is oversampled with a clock-enable tick, and each bit is sampled at its centre.
- Each good frame gives a one-cycle valid strobe with the byte. Each bad stop bit gives a framing-error strobe.
- Used for loopback checking of the transmitter and as the receive half of the board UART.

Parameters:
- OVERSAMPLE, 16, sample_tick pulses per bit period. Must be even and at least 4.
- DATA_BITS, 8, payload bits per frame, sent LSB first.

Ports:
- clk_in  input  1  system clock; all logic is on its rising edge
- reset  input  1  asynchronous, active-low reset
- sample_tick  input  1  oversample enable, one clk_in cycle wide, OVERSAMPLE per bit period
- rx_in  input  1  serial line; idles high; asynchronous to clk_in
- data_out  output  DATA_BITS  last correctly received byte
- data_valid  output  1  one-cycle pulse when data_out updates
- frame_err  output  1  one-cycle pulse when the stop bit samples low
- busy  output  1  high whenever the state is not IDLE

Behaviour:
Clock and reset:
- One clock, clk_in. Reset is asynchronous and active-low, port reset.
- Reset values: data_out=0, data_valid=0, frame_err=0, busy=0, state=IDLE, counters=0, synchroniser flops=1.
- Reset takes effect immediately, including mid-frame. Any partial byte is discarded and no strobe is issued.

Input synchronisation:
- rx_in passes through a 2-flop synchroniser clocked every clk_in cycle. rx_s below means the synchroniser output.

Counters and sampling:
- The tick counter (width clog2(OVERSAMPLE)) and bit counter advance only on cycles where sample_tick=1.
- On all other cycles the state machine holds.

States:
- IDLE: on sample_tick with rx_s=0, go to START with tick_cnt=0. Otherwise stay.
- START: increment tick_cnt on each tick. At tick_cnt==OVERSAMPLE/2-1 (centre of the start bit):
  - if rx_s=0, go to DATA with tick_cnt=0 and bit_cnt=0;
  - if rx_s=1, treat as a glitch and return to IDLE with no strobe.
- DATA: at tick_cnt==OVERSAMPLE-1, shift rx_s into the MSB of the shift register (right shift, so bit 0 arrives first), reset tick_cnt to 0, and increment bit_cnt. After the DATA_BITS-th sample, go to STOP.
- STOP: at tick_cnt==OVERSAMPLE-1, sample rx_s:
  - if 1, data_out<=shift register, pulse data_valid, go to IDLE;
  - if 0, pulse frame_err, leave data_out unchanged, go to BREAK_WAIT.
- BREAK_WAIT: stay until a tick samples rx_s=1, then go to IDLE. A line held low (break) therefore never retriggers a frame.

Timing:
- data_valid or frame_err rises on the clk_in edge after the tick that samples the stop bit. Each is exactly one cycle wide.
- data_valid and frame_err are never high together.
- The transition to IDLE happens at mid-stop, so a back-to-back start bit after a single stop bit is detected.
- There is no backpressure. A consumer that misses a data_valid loses that byte; data_out holds until the next good frame.

Decomposition:
- Shared package uart_pkg holds:
  - 3-bit state encodings RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK, kept distinct from the transmitter's encodings;
  - UART_DATA_BITS=8;
  - UART_OVERSAMPLE=16.
- One sub-module, uart_rx_sync: 2-flop synchroniser with reset-to-1. It is reusable by later receive-side blocks.

Test Plan:
All scenarios use OVERSAMPLE=16 and sample_tick=1 every cycle unless noted; each bit lasts 16 ticks.
- Frame 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) -> data_out=8'hA5, data_valid high exactly 1 cycle, frame_err=0, busy low after mid-stop.
- rx_in low for 4 ticks, then high -> no data_valid and no frame_err; busy returns to 0 at tick 8.
- Frame 0x3C with stop bit 0, line then held low for 40 ticks, then high, then frame 0x55 -> one frame_err pulse, data_out stays 8'hA5 and no start is detected during the low hold, then data_out=8'h55 with one data_valid pulse.
- Back-to-back 0x00 then 0xFF, one stop bit each -> two data_valid pulses exactly 160 ticks apart, with values 8'h00 then 8'hFF.
- reset pulled low after 3 data bits of 0x81 -> outputs 0 immediately, busy=0. After release, a fresh 0x81 frame gives data_out=8'h81.
- sample_tick high 1 cycle in 4, frame 0x5A -> data_out=8'h5A; data_valid rises the cycle after the stop-sampling tick.
